// File: rtl/alu4_nibble_seq.sv
// rtl/alu4_nibble_seq.sv - multi-nibble sequencer for the 4-bit ALU; define ALU4_SEQ_SLOW_EN for registered two-cycle-per-nibble issue
module alu4_nibble_seq #(
    parameter int NIBBLES = 4,
    parameter int LEN_W   = 3
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 cmd_valid,
    output logic                 cmd_ready,
    input  logic [3:0]           cmd_op,
    input  logic [LEN_W-1:0]     cmd_len,
    input  logic                 cmd_msb_first,
    input  logic                 cmd_ci,
    input  logic                 cmd_rci,
    input  logic [4*NIBBLES-1:0] cmd_a,
    input  logic [4*NIBBLES-1:0] cmd_b,
    output logic [3:0]           alu_op,
    output logic [3:0]           alu_a,
    output logic [3:0]           alu_b,
    output logic                 alu_ci,
    output logic                 alu_rci,
    input  logic [3:0]           alu_out,
    input  logic                 alu_co,
    input  logic                 alu_rco,
    input  logic                 alu_ovf,
    output logic                 res_valid,
    input  logic                 res_ready,
    output logic [4*NIBBLES-1:0] res_data,
    output logic                 res_co,
    output logic                 res_rco,
    output logic                 res_ovf,
    output logic                 res_zero
);
    localparam int W     = 4 * NIBBLES;
    // Counter must hold NIBBLES (up to 8) and any raw cmd_len value
    localparam int CNT_W = (LEN_W + 1 > 4) ? LEN_W + 1 : 4;
    localparam logic [CNT_W-1:0] L_MAX = CNT_W'(NIBBLES);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    state_t           r_state;
    state_t           w_next;

    logic [W-1:0]     r_a;
    logic [W-1:0]     r_b;
    logic [3:0]       r_op;
    logic [CNT_W-1:0] r_len;
    logic [CNT_W-1:0] r_k;
    logic             r_msb;
    logic             r_ci0;
    logic             r_rci0;
    logic [W-1:0]     r_data;
    logic             r_co;
    logic             r_rco;
    logic             r_ovf;
    logic             r_zero;

    logic [CNT_W-1:0] w_len_in;
    logic [CNT_W-1:0] w_len_eff;
    logic [CNT_W-1:0] w_idx;
    logic [CNT_W-1:0] w_last_k;
    logic [W-1:0]     w_a_shift;
    logic [W-1:0]     w_b_shift;
    logic [3:0]       w_a_nib;
    logic [3:0]       w_b_nib;
    logic             w_ci_sel;
    logic             w_rci_sel;
    logic [W-1:0]     w_data_ins;
    logic             w_capture;

`ifdef ALU4_SEQ_SLOW_EN
    logic             r_phase;
    logic [3:0]       r_alu_a;
    logic [3:0]       r_alu_b;
    logic             r_alu_ci;
    logic             r_alu_rci;
    assign w_capture = r_phase;
`else
    assign w_capture = 1'b1;
`endif

    // Zero or oversize lengths mean "all nibbles"
    assign w_len_in   = CNT_W'(cmd_len);
    assign w_len_eff  = (w_len_in == '0 || w_len_in > L_MAX) ? L_MAX : w_len_in;
    assign w_last_k   = r_len - CNT_W'(1);
    assign w_idx      = r_msb ? (r_len - r_k - CNT_W'(1)) : r_k;
    assign w_a_shift  = r_a >> {w_idx, 2'b00};
    assign w_b_shift  = r_b >> {w_idx, 2'b00};
    assign w_a_nib    = w_a_shift[3:0];
    assign w_b_nib    = w_b_shift[3:0];
    // First nibble takes the command carries, later ones chain the captured carries
    assign w_ci_sel   = (r_k == '0) ? r_ci0 : r_co;
    assign w_rci_sel  = (r_k == '0) ? r_rci0 : r_rco;
    // res_data is cleared on accept and each nibble written once, so OR-in is exact
    assign w_data_ins = W'(alu_out) << {w_idx, 2'b00};

    assign res_data = r_data;
    assign res_co   = r_co;
    assign res_rco  = r_rco;
    assign res_ovf  = r_ovf;
    assign res_zero = r_zero;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state and handshake/ALU-drive outputs; ALU inputs are zero outside RUN
    always_comb begin
        w_next    = r_state;
        cmd_ready = 1'b0;
        res_valid = 1'b0;
        alu_op    = 4'h0;
        alu_a     = 4'h0;
        alu_b     = 4'h0;
        alu_ci    = 1'b0;
        alu_rci   = 1'b0;
        case (r_state)
            S_IDLE: begin
                cmd_ready = 1'b1;
                if (cmd_valid) begin
                    w_next = S_RUN;
                end
            end
            S_RUN: begin
                alu_op = r_op;
`ifdef ALU4_SEQ_SLOW_EN
                alu_a   = r_alu_a;
                alu_b   = r_alu_b;
                alu_ci  = r_alu_ci;
                alu_rci = r_alu_rci;
`else
                alu_a   = w_a_nib;
                alu_b   = w_b_nib;
                alu_ci  = w_ci_sel;
                alu_rci = w_rci_sel;
`endif
                if (w_capture && r_k == w_last_k) begin
                    w_next = S_DONE;
                end
            end
            S_DONE: begin
                res_valid = 1'b1;
                if (res_ready) begin
                    w_next = S_IDLE;
                end
            end
            default: w_next = S_IDLE;
        endcase
    end

    // Command latch, nibble counter and result/flag accumulation
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a    <= '0;
            r_b    <= '0;
            r_op   <= 4'h0;
            r_len  <= '0;
            r_k    <= '0;
            r_msb  <= 1'b0;
            r_ci0  <= 1'b0;
            r_rci0 <= 1'b0;
            r_data <= '0;
            r_co   <= 1'b0;
            r_rco  <= 1'b0;
            r_ovf  <= 1'b0;
            r_zero <= 1'b0;
        end else begin
            if (r_state == S_IDLE && cmd_valid) begin
                r_a    <= cmd_a;
                r_b    <= cmd_b;
                r_op   <= cmd_op;
                r_len  <= w_len_eff;
                r_k    <= '0;
                r_msb  <= cmd_msb_first;
                r_ci0  <= cmd_ci;
                r_rci0 <= cmd_rci;
                r_data <= '0;
                r_zero <= 1'b1;
            end else if (r_state == S_RUN && w_capture) begin
                r_data <= r_data | w_data_ins;
                r_co   <= alu_co;
                r_rco  <= alu_rco;
                r_ovf  <= alu_ovf;
                r_zero <= r_zero & (alu_out == 4'h0);
                r_k    <= (r_k == w_last_k) ? '0 : r_k + CNT_W'(1);
            end
        end
    end

`ifdef ALU4_SEQ_SLOW_EN
    // Issue/capture phase: ALU inputs are registered on issue and dropped after capture
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_phase   <= 1'b0;
            r_alu_a   <= 4'h0;
            r_alu_b   <= 4'h0;
            r_alu_ci  <= 1'b0;
            r_alu_rci <= 1'b0;
        end else if (r_state == S_RUN && !r_phase) begin
            r_phase   <= 1'b1;
            r_alu_a   <= w_a_nib;
            r_alu_b   <= w_b_nib;
            r_alu_ci  <= w_ci_sel;
            r_alu_rci <= w_rci_sel;
        end else begin
            r_phase   <= 1'b0;
            r_alu_a   <= 4'h0;
            r_alu_b   <= 4'h0;
            r_alu_ci  <= 1'b0;
            r_alu_rci <= 1'b0;
        end
    end
`endif

endmodule

// File: doc/alu4_nibble_seq.md
Name: alu4_nibble_seq

Overview:
- Multi-nibble sequencer for the 4-bit ALU datapath.
- Accepts one wide command (operands up to 4*NIBBLES bits, opcode, carries) and issues it to the ALU one nibble per cycle.
- Chains math carry (alu_co→alu_ci) and rotate carry (alu_rco→alu_rci) between nibbles, then returns the assembled result and flags.
- Sits between a requester (host/test logic) and the combinational ALU core.

Parameters:
- NIBBLES, 4, maximum operand width in nibbles (W = 4*NIBBLES), legal 1..8.
- LEN_W, 3, width of cmd_len.

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- cmd_valid  in  1  command offered
- cmd_ready  out  1  sequencer can accept (high only in IDLE)
- cmd_op  in  4  ALU opcode, held on alu_op for the whole command
- cmd_len  in  LEN_W  nibbles to process; 0 or >NIBBLES means NIBBLES
- cmd_msb_first  in  1  1 = issue MS nibble first (right rotates/shifts)
- cmd_ci  in  1  math carry into first nibble
- cmd_rci  in  1  rotate carry into first nibble
- cmd_a  in  W  operand A
- cmd_b  in  W  operand B
- alu_op  out  4  to ALU opcode
- alu_a  out  4  to ALU input A nibble
- alu_b  out  4  to ALU input B nibble
- alu_ci  out  1  to ALU math carry in
- alu_rci  out  1  to ALU rotate carry in
- alu_out  in  4  ALU result nibble
- alu_co  in  1  ALU math carry out
- alu_rco  in  1  ALU rotate carry out
- alu_ovf  in  1  ALU overflow
- res_valid  out  1  result available
- res_ready  in  1  requester takes result
- res_data  out  W  assembled result
- res_co  out  1  final math carry
- res_rco  out  1  final rotate carry
- res_ovf  out  1  overflow of last nibble issued
- res_zero  out  1  all processed nibbles zero

Behaviour:
- States: IDLE, RUN, DONE. Reset (async, rst_n=0) forces IDLE.
- Reset values: cmd_ready=1, res_valid=0, res_data=0, all res flags 0, all alu_* outputs 0, counter 0.
- IDLE: cmd_ready=1. At an edge with cmd_valid=1:
  - Latch operands, op, effective length L, direction and carries; clear res_data; set zero accumulator=1; go to RUN.
- RUN: cmd_ready=0. Counter k=0..L-1; nibble index i=k (LSB-first) or i=L-1-k (MSB-first).
  - Drive alu_a=A[4i+3:4i], alu_b=B[4i+3:4i], alu_op=latched op.
  - alu_ci/alu_rci = latched cmd_ci/cmd_rci for k=0, else the alu_co/alu_rco captured at the previous edge.
  - Each edge captures alu_out into res_data[4i+3:4i], captures co/rco/ovf, and ANDs (alu_out==0) into the zero accumulator.
  - After the edge capturing k=L-1, go to DONE.
- Latency: res_valid rises L edges after the accept edge. Example: L=4 accepted at edge 0 gives res_valid high after edge 4.
- DONE: res_valid=1; res_* stable. At an edge with res_ready=1, go to IDLE.
  - res_valid drops; res_data and flags hold their last values until the next accept.
  - cmd_ready rises the cycle after the result handshake. There is no same-cycle turnaround.
- Nibbles at index ≥L read 0 in res_data.
- cmd_valid outside IDLE is ignored: no accept, no state corruption.
- alu_* drive 0 outside RUN.
- res_ready outside DONE has no effect.
- Reset asserted in RUN or DONE aborts immediately: outputs return to reset values and the in-flight result is discarded.

Optional Feature:
- Macro ALU4_SEQ_SLOW_EN.
- Defined: each nibble takes two cycles. The ISSUE cycle registers alu_* outputs; the CAPTURE cycle samples the ALU returns. This gives registered ALU inputs for timing relief. Latency is 2L edges, and the chaining rules are otherwise identical.
- Undefined: one nibble per cycle as above, with alu_ci/alu_rci combinationally selected.

Test Plan:
Bench ALU model: alu_out=(a+b+ci)[3:0], alu_co=carry, alu_rco=alu_rci, alu_ovf=signed overflow.
- Add, A=0x12FF, B=0x0001, ci=0, len=4 -> res_data=0x1300, co=0, zero=0, res_valid 4 edges after accept.
- A=0xFFFF, B=0x0001, len=0 (full) -> res_data=0x0000, co=1, zero=1, ovf=0.
- A=0x00FF, B=0x0001, len=2 -> res_data=0x0000, co=1, zero=1, upper nibbles 0, latency 2.
- A=0x1234, B=0, msb_first=1, rci=1 -> alu_a sequence 1,2,3,4; alu_rci=1 on all nibbles; res_data=0x1234.
- Backpressure: hold res_ready=0 for 5 cycles in DONE -> res_* stable, cmd_ready=0, second cmd_valid ignored; res_ready=1 -> IDLE, next command accepted the following edge.
- Reset pulse during RUN at k=2 -> all outputs at reset values the same cycle; a fresh command afterwards completes correctly.
- Repeat the first scenario with ALU4_SEQ_SLOW_EN defined -> same result, latency 8 edges.
